// File: rtl/csp_cmd_dec.sv
// CSP command decoder: parses SOP"_Debug payload into register reads/writes.
// Write data is held in a local buffer until the frame CRC is confirmed good.
module csp_cmd_dec #(
    parameter int unsigned MAXLEN = 16,
    parameter int unsigned AW     = 8
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          rx_sof,
    input  logic          rx_vld,
    input  logic [7:0]    rx_byte,
    input  logic          rx_eof,
    input  logic          rx_crc_ok,
    output logic [AW-1:0] reg_addr,
    output logic          reg_we,
    output logic [7:0]    reg_wdat,
    output logic          reg_re,
    input  logic [7:0]    reg_rdat,
    output logic          tx_vld,
    output logic [7:0]    tx_byte,
    input  logic          tx_rdy,
    output logic          busy,
    output logic          err
);

    localparam int unsigned IW       = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int unsigned DEPTH    = 1 << IW;
    localparam logic [5:0]  MAXLEN_W = 6'(MAXLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR,
        S_WDAT,
        S_WEOF,
        S_COMMIT,
        S_RDEOF,
        S_RD,
        S_RSP
    } state_e;

    state_e          state_q, state_d;
    logic            rd_q, rd_d;
    logic            fix_q, fix_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            cap_q, cap_d;
    logic [7:0]      txb_q, txb_d;
    logic            err_q, err_d;
    logic [7:0]      wbuf_q [DEPTH];
    logic [7:0]      wbuf_d [DEPTH];

    logic            abort;
    logic            last;
    logic [5:0]      len_new;
    logic [AW-1:0]   addr_nxt;
    logic [IW-1:0]   wbuf_idx;

    assign len_new  = {1'b0, rx_byte[4:0]} + 6'd1;
    assign last     = (cnt_q == (len_q - 6'd1));
    assign addr_nxt = fix_q ? addr_q : (addr_q + AW'(1'b1));
    assign wbuf_idx = cnt_q[IW-1:0];

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        fix_d   = fix_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cap_d   = cap_q;
        txb_d   = txb_q;
        err_d   = 1'b0;
        abort   = 1'b0;
        wbuf_d  = wbuf_q;

        case (state_q)
            S_IDLE: begin
                if (rx_sof && rx_vld) begin
                    if (len_new > MAXLEN_W) begin
                        err_d = 1'b1;
                    end else begin
                        rd_d    = rx_byte[7];
                        fix_d   = rx_byte[6];
                        len_d   = len_new;
                        cnt_d   = '0;
                        state_d = S_ADR;
                    end
                end
            end

            S_ADR: begin
                if (rx_sof) begin
                    abort = 1'b1;
                end else if (rx_vld) begin
                    addr_d = rx_byte;
                    if (rd_q) begin
                        // A read frame ends at the address byte, so EOF may ride along with it
                        if (rx_eof) begin
                            if (rx_crc_ok) begin
                                cnt_d   = '0;
                                cap_d   = 1'b0;
                                state_d = S_RD;
                            end else begin
                                abort = 1'b1;
                            end
                        end else begin
                            state_d = S_RDEOF;
                        end
                    end else if (rx_eof) begin
                        abort = 1'b1;
                    end else begin
                        state_d = S_WDAT;
                    end
                end else if (rx_eof) begin
                    abort = 1'b1;
                end
            end

            S_WDAT: begin
                if (rx_sof) begin
                    abort = 1'b1;
                end else if (rx_vld) begin
                    wbuf_d[wbuf_idx] = rx_byte;
                    cnt_d            = cnt_q + 6'd1;
                    if (last) begin
                        if (!rx_eof) begin
                            state_d = S_WEOF;
                        end else if (rx_crc_ok) begin
                            cnt_d   = '0;
                            state_d = S_COMMIT;
                        end else begin
                            abort = 1'b1;
                        end
                    end else if (rx_eof) begin
                        abort = 1'b1;
                    end
                end else if (rx_eof) begin
                    abort = 1'b1;
                end
            end

            S_WEOF: begin
                if (rx_sof || rx_vld) begin
                    abort = 1'b1;
                end else if (rx_eof) begin
                    if (rx_crc_ok) begin
                        cnt_d   = '0;
                        state_d = S_COMMIT;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end

            S_COMMIT: begin
                err_d  = rx_sof;
                cnt_d  = cnt_q + 6'd1;
                addr_d = addr_nxt;
                if (last) begin
                    state_d = S_IDLE;
                end
            end

            S_RDEOF: begin
                if (rx_sof || rx_vld) begin
                    abort = 1'b1;
                end else if (rx_eof) begin
                    if (rx_crc_ok) begin
                        cnt_d   = '0;
                        cap_d   = 1'b0;
                        state_d = S_RD;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end

            S_RD: begin
                err_d = rx_sof;
                // First cycle strobes reg_re, second captures the returned data
                if (!cap_q) begin
                    cap_d = 1'b1;
                end else begin
                    cap_d   = 1'b0;
                    txb_d   = reg_rdat;
                    addr_d  = addr_nxt;
                    state_d = S_RSP;
                end
            end

            S_RSP: begin
                err_d = rx_sof;
                if (tx_rdy) begin
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        state_d = S_RD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            fix_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            cap_q   <= 1'b0;
            txb_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            fix_q   <= fix_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cap_q   <= cap_d;
            txb_q   <= txb_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents need no reset: COMMIT is only reachable after a full refill
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
    end

    assign reg_addr = addr_q;
    assign reg_we   = (state_q == S_COMMIT);
    assign reg_wdat = (state_q == S_COMMIT) ? wbuf_q[wbuf_idx] : '0;
    assign reg_re   = (state_q == S_RD) && !cap_q;
    assign tx_vld   = (state_q == S_RSP);
    assign tx_byte  = txb_q;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_csp_cmd_dec.sv
// Directed bench for csp_cmd_dec: write/read frames, aborts, wrap and reset.
module tb_csp_cmd_dec;

    logic       clk;
    logic       srst;
    logic       rx_sof, rx_vld, rx_eof, rx_crc_ok;
    logic [7:0] rx_byte;
    logic [7:0] reg_addr;
    logic       reg_we, reg_re;
    logic [7:0] reg_wdat;
    logic [7:0] reg_rdat;
    logic       tx_vld, tx_rdy;
    logic [7:0] tx_byte;
    logic       busy, err;

    int n_vec   = 0;
    int n_err   = 0;
    int we_cnt  = 0;
    int re_cnt  = 0;
    int err_cnt = 0;
    int rd_idx  = 0;
    int base;

    logic [7:0] rd_data [4];

    csp_cmd_dec #(.MAXLEN(16), .AW(8)) dut (
        .clk      (clk),
        .srst     (srst),
        .rx_sof   (rx_sof),
        .rx_vld   (rx_vld),
        .rx_byte  (rx_byte),
        .rx_eof   (rx_eof),
        .rx_crc_ok(rx_crc_ok),
        .reg_addr (reg_addr),
        .reg_we   (reg_we),
        .reg_wdat (reg_wdat),
        .reg_re   (reg_re),
        .reg_rdat (reg_rdat),
        .tx_vld   (tx_vld),
        .tx_byte  (tx_byte),
        .tx_rdy   (tx_rdy),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank read port: data returned the cycle after reg_re
    always @(posedge clk) begin
        if (reg_re) begin
            reg_rdat <= rd_data[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (reg_we) we_cnt++;
        if (reg_re) re_cnt++;
        if (err)    err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sof, input logic vld, input logic [7:0] b,
                         input logic eof, input logic crc);
        rx_sof    = sof;
        rx_vld    = vld;
        rx_byte   = b;
        rx_eof    = eof;
        rx_crc_ok = crc;
        step();
        rx_sof    = 1'b0;
        rx_vld    = 1'b0;
        rx_byte   = 8'h00;
        rx_eof    = 1'b0;
        rx_crc_ok = 1'b0;
    endtask

    initial begin
        rd_data[0] = 8'h55;
        rd_data[1] = 8'hAA;
        rd_data[2] = 8'h77;
        rd_data[3] = 8'h00;
        reg_rdat  = 8'h00;
        srst      = 1'b1;
        rx_sof    = 1'b0;
        rx_vld    = 1'b0;
        rx_byte   = 8'h00;
        rx_eof    = 1'b0;
        rx_crc_ok = 1'b0;
        tx_rdy    = 1'b0;
        step(); step(); step();
        srst = 1'b0;

        chk("rst_busy",  busy,     0);
        chk("rst_err",   err,      0);
        chk("rst_we",    reg_we,   0);
        chk("rst_re",    reg_re,   0);
        chk("rst_txvld", tx_vld,   0);
        chk("rst_txb",   tx_byte,  0);
        chk("rst_addr",  reg_addr, 0);
        chk("rst_wdat",  reg_wdat, 0);

        // W, inc, LEN=2 @20h: 55h, AAh, EOF on last byte
        drive(1, 1, 8'h01, 0, 0);
        chk("w1_busy", busy, 1);
        drive(0, 1, 8'h20, 0, 0);
        drive(0, 1, 8'h55, 0, 0);
        drive(0, 1, 8'hAA, 1, 1);
        chk("w1_we0",   reg_we,   1);
        chk("w1_addr0", reg_addr, 8'h20);
        chk("w1_dat0",  reg_wdat, 8'h55);
        chk("w1_err",   err,      0);
        step();
        chk("w1_we1",   reg_we,   1);
        chk("w1_addr1", reg_addr, 8'h21);
        chk("w1_dat1",  reg_wdat, 8'hAA);
        step();
        chk("w1_we_end", reg_we, 0);
        chk("w1_idle",   busy,   0);
        chk("w1_wecnt",  we_cnt, 2);

        // Same frame, bad CRC
        base = we_cnt;
        drive(1, 1, 8'h01, 0, 0);
        drive(0, 1, 8'h20, 0, 0);
        drive(0, 1, 8'h55, 0, 0);
        drive(0, 1, 8'hAA, 1, 0);
        chk("crc_err",  err,    1);
        chk("crc_busy", busy,   0);
        chk("crc_we",   reg_we, 0);
        step();
        chk("crc_err_end", err,     0);
        chk("crc_errcnt",  err_cnt, 1);
        chk("crc_nowe",    we_cnt,  base);

        // R, FIX, LEN=2 @C3h, transmitter stalls 3 cycles on first byte
        drive(1, 1, 8'hC1, 0, 0);
        drive(0, 1, 8'hC3, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        chk("r_re0",    reg_re,   1);
        chk("r_addr0",  reg_addr, 8'hC3);
        chk("r_vld_lo", tx_vld,   0);
        step();
        chk("r_cap_re",  reg_re, 0);
        chk("r_cap_vld", tx_vld, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("r_stall_vld", tx_vld,  1);
            chk("r_stall_b",   tx_byte, 8'h55);
            step();
        end
        tx_rdy = 1'b1;
        chk("r_hs0_b", tx_byte, 8'h55);
        step();
        tx_rdy = 1'b0;
        chk("r_re1",   reg_re,   1);
        chk("r_addr1", reg_addr, 8'hC3);
        chk("r_vld1_lo", tx_vld, 0);
        step();
        step();
        chk("r_vld1", tx_vld,  1);
        chk("r_b1",   tx_byte, 8'hAA);
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        chk("r_idle",  busy,   0);
        chk("r_vld_end", tx_vld, 0);
        chk("r_recnt", re_cnt, 2);

        // Address wrap: W, inc, LEN=3 @FEh
        drive(1, 1, 8'h02, 0, 0);
        drive(0, 1, 8'hFE, 0, 0);
        drive(0, 1, 8'h11, 0, 0);
        drive(0, 1, 8'h22, 0, 0);
        drive(0, 1, 8'h33, 1, 1);
        chk("wr_a0", reg_addr, 8'hFE);
        chk("wr_d0", reg_wdat, 8'h11);
        step();
        chk("wr_a1", reg_addr, 8'hFF);
        chk("wr_d1", reg_wdat, 8'h22);
        step();
        chk("wr_a2",  reg_addr, 8'h00);
        chk("wr_d2",  reg_wdat, 8'h33);
        chk("wr_we2", reg_we,   1);
        step();
        chk("wr_done", reg_we, 0);

        // Truncated LEN=4 write, then a good LEN=1 write via WEOF
        base = we_cnt;
        drive(1, 1, 8'h03, 0, 0);
        drive(0, 1, 8'h40, 0, 0);
        drive(0, 1, 8'h01, 0, 0);
        drive(0, 1, 8'h02, 1, 1);
        chk("tr_err",  err,    1);
        chk("tr_busy", busy,   0);
        step();
        chk("tr_nowe", we_cnt, base);
        drive(1, 1, 8'h00, 0, 0);
        drive(0, 1, 8'h10, 0, 0);
        drive(0, 1, 8'h5A, 0, 0);
        chk("tr_weof_busy", busy, 1);
        drive(0, 0, 8'h00, 1, 1);
        chk("tr2_we",   reg_we,   1);
        chk("tr2_addr", reg_addr, 8'h10);
        chk("tr2_dat",  reg_wdat, 8'h5A);
        step();
        chk("tr2_idle", busy, 0);

        // LEN=17 rejected at CMD; LEN=16 accepted; SOF mid-frame aborts
        drive(1, 1, 8'h10, 0, 0);
        chk("len17_err",  err,  1);
        chk("len17_busy", busy, 0);
        drive(0, 1, 8'h33, 0, 0);
        chk("stray_busy", busy, 0);
        chk("stray_err",  err,  0);
        drive(1, 1, 8'h0F, 0, 0);
        chk("len16_busy", busy, 1);
        chk("len16_err",  err,  0);
        drive(1, 1, 8'h00, 0, 0);
        chk("sof_err",  err,  1);
        chk("sof_busy", busy, 0);

        // R, inc, LEN=1 with EOF on the address byte; reset during RSP
        drive(1, 1, 8'h80, 0, 0);
        drive(0, 1, 8'h05, 1, 1);
        chk("rs_re",   reg_re,   1);
        chk("rs_addr", reg_addr, 8'h05);
        step();
        step();
        chk("rs_vld", tx_vld,  1);
        chk("rs_b",   tx_byte, 8'h77);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("rs_vld_rst",  tx_vld,   0);
        chk("rs_busy_rst", busy,     0);
        chk("rs_txb_rst",  tx_byte,  0);
        chk("rs_addr_rst", reg_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
